// File: rtl/nios2_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mult_pkg
// Purpose  : Shared constants, types and helpers for the Nios II multiplier.
//            CELL_W         - width of one unsigned partial-product cell
//            cell_count()   - number of CELL_W x CELL_W cells for a DATA_W
//            mult_mode_t    - operand signedness combination (UU, SU, SS)
//            s1_payload_t   - operand-stage payload (operands, sign flags, tag)
//                             sized for the widest legal configuration. Each
//                             instance keeps only the low DATA_W / TAG_W bits.
// Revision : 1.0 - initial release
// ============================================================================
package nios2_mult_pkg;

    localparam int CELL_W     = 16;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_TAG_W  = 16;

    typedef enum logic [1:0] {
        UU = 2'd0,
        SU = 2'd1,
        SS = 2'd2
    } mult_mode_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] a;
        logic [MAX_DATA_W-1:0] b;
        logic                  signed_a;
        logic                  signed_b;
        logic [MAX_TAG_W-1:0]  tag;
    } s1_payload_t;

    // Number of partial-product cells needed to tile a data_w x data_w product.
    function automatic int cell_count(input int data_w);
        return (data_w / CELL_W) * (data_w / CELL_W);
    endfunction

    // Signedness combination of one operation. An operation with exactly one
    // signed operand is reported as SU regardless of which operand it is.
    function automatic mult_mode_t mode_of(input logic sa, input logic sb);
        if (sa && sb) begin
            return SS;
        end else if (sa || sb) begin
            return SU;
        end
        return UU;
    endfunction

endpackage : nios2_mult_pkg
`default_nettype wire

// File: rtl/nios2_mult_pp_cell.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mult_pp_cell
// Purpose  : Registered CELL_W x CELL_W unsigned multiplier. The product is
//            captured on the rising edge while en_i is high and is held
//            otherwise. The asynchronous reset clears it.
// Ports    : clk    - clock
//            reset  - asynchronous active-high clear
//            en_i   - pipeline advance enable
//            a_i    - CELL_W-bit unsigned slice of operand A
//            b_i    - CELL_W-bit unsigned slice of operand B
//            p_o    - registered 2*CELL_W-bit product
// Revision : 1.0 - initial release
// ============================================================================
module nios2_mult_pp_cell
    import nios2_mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [CELL_W-1:0]     a_i,
    input  logic [CELL_W-1:0]     b_i,
    output logic [2*CELL_W-1:0]   p_o
);

    logic [2*CELL_W-1:0] p_q;
    logic [2*CELL_W-1:0] p_d;

    always_comb begin
        p_d = p_q;
        if (en_i) begin
            p_d = (2*CELL_W)'(a_i) * (2*CELL_W)'(b_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule : nios2_mult_pp_cell
`default_nettype wire

// File: rtl/nios2_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mult_unit
// Purpose  : Three-stage pipelined DATA_W x DATA_W multiplier that returns the
//            full 2*DATA_W-bit product (lo/hi words). It has a valid/ready
//            handshake, global-stall backpressure and a synchronous flush.
//            S1 : operand register (operands, sign flags, tag)
//            S2 : (DATA_W/16)^2 registered 16x16 unsigned partial products
//                 plus the two-sign correction terms
//            S3 : sum register, which drives out_* directly
//            Results appear in the third cycle after the handshake cycle.
// Config   : NIOS2_MULT_SIGNED_EN - when defined, in_signed_a/in_signed_b
//            are honoured and the correction logic is built. When undefined,
//            all operations are unsigned and have the same latency.
// Ports    : clk, reset (async, active-high), flush (sync kill of in-flight)
//            in_valid/in_ready, in_a, in_b, in_signed_a, in_signed_b, in_tag
//            out_valid/out_ready, out_lo, out_hi, out_tag
// Params   : DATA_W - operand width, multiple of 16 in 16..64
//            TAG_W  - sideband tag width (at most 16)
// Revision : 1.0 - initial release
// ============================================================================
module nios2_mult_unit
    import nios2_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_signed_a,
    input  logic              in_signed_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_lo,
    output logic [DATA_W-1:0] out_hi,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int NS     = DATA_W / CELL_W;
    localparam int NCELL  = cell_count(DATA_W);
    localparam int PROD_W = 2 * DATA_W;
    // Two guard bits so that the correction subtraction cannot alias into the
    // kept product bits before truncation.
    localparam int SUM_W  = 2 * DATA_W + 2;

    // ------------------------------------------------------------------------
    // Handshake / global enable
    // ------------------------------------------------------------------------
    logic stall;
    logic adv;
    logic accept;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;

    // A result the consumer is not taking freezes the whole pipe. When
    // out_ready is high in the same cycle, the pipeline moves.
    assign stall    = s3_valid_q && !out_ready;
    assign adv      = !stall;
    assign in_ready = !stall && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
        end else if (adv) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
        end
    end

    // ------------------------------------------------------------------------
    // S1: operand register
    // ------------------------------------------------------------------------
    s1_payload_t       s1_q, s1_d;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    always_comb begin
        s1_d = s1_q;
        if (accept) begin
            s1_d.a        = MAX_DATA_W'(in_a);
            s1_d.b        = MAX_DATA_W'(in_b);
            s1_d.signed_a = in_signed_a;
            s1_d.signed_b = in_signed_b;
            s1_d.tag      = MAX_TAG_W'(in_tag);
        end
    end

    assign s1_a = s1_q.a[DATA_W-1:0];
    assign s1_b = s1_q.b[DATA_W-1:0];

    // ------------------------------------------------------------------------
    // S2: partial-product cells (cell index = row * NS + col)
    // ------------------------------------------------------------------------
    logic [2*CELL_W-1:0] pp [NCELL];

    for (genvar gi = 0; gi < NS; gi++) begin : g_pp_row
        for (genvar gj = 0; gj < NS; gj++) begin : g_pp_col
            nios2_mult_pp_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .en_i  (adv),
                .a_i   (s1_a[gi*CELL_W +: CELL_W]),
                .b_i   (s1_b[gj*CELL_W +: CELL_W]),
                .p_o   (pp[gi*NS + gj])
            );
        end
    end

    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    assign s2_tag_d = adv ? s1_q.tag[TAG_W-1:0] : s2_tag_q;

`ifdef NIOS2_MULT_SIGNED_EN
    // A negative two's-complement operand is the unsigned pattern minus
    // 2^DATA_W. The cross term of that offset is the other operand shifted
    // up by DATA_W, and it is subtracted in S3.
    logic [DATA_W-1:0] ca_q, ca_d;
    logic [DATA_W-1:0] cb_q, cb_d;

    always_comb begin
        ca_d = ca_q;
        cb_d = cb_q;
        if (adv) begin
            ca_d = (s1_q.signed_a && s1_a[DATA_W-1]) ? s1_b : '0;
            cb_d = (s1_q.signed_b && s1_b[DATA_W-1]) ? s1_a : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ca_q <= '0;
            cb_q <= '0;
        end else begin
            ca_q <= ca_d;
            cb_q <= cb_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // S3: weighted sum of partial products, minus sign correction
    // ------------------------------------------------------------------------
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                sum = sum + (SUM_W'(pp[i*NS + j]) << (CELL_W * (i + j)));
            end
        end
`ifdef NIOS2_MULT_SIGNED_EN
        sum = sum - ((SUM_W'(ca_q) + SUM_W'(cb_q)) << DATA_W);
`endif
    end

    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    always_comb begin
        lo_d  = lo_q;
        hi_d  = hi_q;
        tag_d = tag_q;
        if (adv) begin
            lo_d  = sum[DATA_W-1:0];
            hi_d  = sum[PROD_W-1:DATA_W];
            tag_d = s2_tag_q;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_tag_q   <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_q       <= s1_d;
            s2_tag_q   <= s2_tag_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            tag_q      <= tag_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_lo    = lo_q;
    assign out_hi    = hi_q;
    assign out_tag   = tag_q;

    // Payload bits above the configured widths, the sum guard bits and (in
    // the unsigned build) the sign flags carry no information.
    logic unused_bits;
`ifdef NIOS2_MULT_SIGNED_EN
    assign unused_bits = ^{s1_q.a >> DATA_W, s1_q.b >> DATA_W,
                           s1_q.tag >> TAG_W, sum[SUM_W-1:PROD_W]};
`else
    assign unused_bits = ^{s1_q.a >> DATA_W, s1_q.b >> DATA_W,
                           s1_q.tag >> TAG_W, sum[SUM_W-1:PROD_W],
                           s1_q.signed_a, s1_q.signed_b};
`endif

endmodule : nios2_mult_unit
`default_nettype wire

// File: tb/tb_nios2_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_mult_unit
// Purpose  : Self-checking bench for nios2_mult_unit (DATA_W=32, TAG_W=5).
//            A directed vector table checks products and latency. Hand-written
//            sequences cover stall, flush and mid-stream reset. A randomized
//            stream is compared against a queue-based product model.
// Config   : NIOS2_MULT_SIGNED_EN selects signed or unsigned expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_mult_unit;

    localparam int W  = 32;
    localparam int TW = 5;

`ifdef NIOS2_MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_signed_a;
    logic          in_signed_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_lo;
    logic [W-1:0]  out_hi;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    nios2_mult_unit #(.DATA_W(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed_a (in_signed_a),
        .in_signed_b (in_signed_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lo      (out_lo),
        .out_hi      (out_hi),
        .out_tag     (out_tag)
    );

    int checks = 0;
    int passed = 0;
    int n_out  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product: sign-extend each operand to 2W bits when it is
    // signed and multiply modulo 2^(2W).
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sa, input logic sb);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{sa && SIGNED_BUILD && a[W-1]}}, a};
        eb = {{W{sb && SIGNED_BUILD && b[W-1]}}, b};
        return ea * eb;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2*W-1:0] prod;
        logic [TW-1:0]  tag;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            chk("in_ready_rule", {63'b0, in_ready}, {63'b0, !(out_valid && !out_ready) && !flush});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {63'b0, out_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_product", {out_hi, out_lo}, e.prod);
                    chk("sb_tag", {59'b0, out_tag}, {59'b0, e.tag});
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e.prod = ref_mul(in_a, in_b, in_signed_a, in_signed_b);
                e.tag  = in_tag;
                sb.push_back(e);
            end
            if (flush) begin
                sb.delete();
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sa;
        logic         sb;
        logic [W-1:0] hs;   // expected hi, signed build
        logic [W-1:0] ls;   // expected lo, signed build
        logic [W-1:0] hu;   // expected hi, unsigned build
        logic [W-1:0] lu;   // expected lo, unsigned build
    } vec_t;

    localparam int NV = 10;
    vec_t vt [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input logic [TW-1:0] tag);
        int n;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        eh = SIGNED_BUILD ? v.hs : v.hu;
        el = SIGNED_BUILD ? v.ls : v.lu;
        in_a        = v.a;
        in_b        = v.b;
        in_signed_a = v.sa;
        in_signed_b = v.sb;
        in_tag      = tag;
        in_valid    = 1'b1;
        #1;
        chk("vec_in_ready", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("vec_latency", 64'(n), 64'd3);
        chk("vec_hi", {32'b0, out_hi}, {32'b0, eh});
        chk("vec_lo", {32'b0, out_lo}, {32'b0, el});
        chk("vec_tag", {59'b0, out_tag}, {59'b0, tag});
        tick();
    endtask

    task automatic rand_inputs(input logic [TW-1:0] tag);
        in_a        = $urandom;
        in_b        = $urandom;
        in_signed_a = 1'($urandom_range(0, 1));
        in_signed_b = 1'($urandom_range(0, 1));
        in_tag      = tag;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int idx;
        logic [W-1:0] ra [8];
        logic [W-1:0] rb [8];

        vt[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 32'h00000001};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'h00000001};
        vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000001};
        vt[3] = '{32'h80000000, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00000000};
        vt[4] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000};
        vt[5] = '{32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000001, 32'hFFFFFFFC};
        vt[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h3FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 32'h00000001};
        vt[7] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vt[8] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000, 32'h40000000, 32'h00000000};
        vt[9] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};

        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_signed_a = 1'b0;
        in_signed_b = 1'b0;
        in_tag      = '0;
        out_ready   = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_lo", {32'b0, out_lo}, 64'd0);
        chk("rst_out_hi", {32'b0, out_hi}, 64'd0);
        chk("rst_out_tag", {59'b0, out_tag}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed table, one operation at a time.
        for (int i = 0; i < NV; i++) begin
            run_vec(vt[i], TW'(i + 3));
        end

        // Eight back-to-back operations with a four-cycle stall mid-stream.
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
        base = n_out;
        idx  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            if (idx < 8) begin
                in_valid    = 1'b1;
                in_a        = ra[idx];
                in_b        = rb[idx];
                in_signed_a = idx[0];
                in_signed_b = idx[1];
                in_tag      = TW'(idx + 16);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 5 && cyc < 9) begin
                chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
                chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
            end
            if (in_valid && in_ready) begin
                idx++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_delivered", 64'(n_out - base), 64'd8);
        chk("stall_pending", 64'(sb.size()), 64'd0);

        // Flush with three operations in flight and the consumer not ready.
        base      = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(TW'(i + 24));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("flush_no_valid", {63'b0, out_valid}, 64'd0);
            tick();
        end
        chk("flush_delivered", 64'(n_out - base), 64'd0);

        // Reset pulsed in the middle of a stream.
        for (int i = 0; i < 4; i++) begin
            rand_inputs(TW'(i + 8));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_out_lo", {32'b0, out_lo}, 64'd0);
        chk("mid_rst_out_hi", {32'b0, out_hi}, 64'd0);
        chk("mid_rst_out_tag", {59'b0, out_tag}, 64'd0);
        chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_idle", {63'b0, out_valid}, 64'd0);
            tick();
        end
        run_vec(vt[3], 5'd30);

        // Randomized traffic with random backpressure and occasional flush.
        for (int cyc = 0; cyc < 400; cyc++) begin
            rand_inputs(TW'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", {63'b0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_nios2_mult_unit
`default_nettype wire
